// File: rtl/seg_scan8_if.sv
// Digit, decimal-point and display-drive signals between a BCD source and the
// seg_scan8 scanner. The master supplies the digits; the slave drives the display.
interface seg_scan8_if;
  logic [3:0] one;
  logic [3:0] ten;
  logic [3:0] hundred;
  logic [3:0] thousand;
  logic [3:0] tenThousand;
  logic [3:0] hundredThousand;
  logic [3:0] mil;
  logic [3:0] tenMil;
  logic [7:0] dp_sel;
  logic       blank_lz;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  modport master (
    output one, ten, hundred, thousand, tenThousand, hundredThousand, mil, tenMil,
    output dp_sel, blank_lz,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  one, ten, hundred, thousand, tenThousand, hundredThousand, mil, tenMil,
    input  dp_sel, blank_lz,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg_scan8.sv
// Eight-digit common-anode seven-segment scanner with per-frame digit snapshot,
// leading-zero blanking, per-digit decimal points and an anode-off ghosting guard.
module seg_scan8 #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GUARD    = 500
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan8_if.slave bus
);
  localparam int unsigned   DW        = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIV_GUARD = DW'(GUARD);

  logic [DW-1:0]   div;
  logic [2:0]      idx;
  logic [7:0][3:0] sh_dig;
  logic [7:0]      sh_dp;
  logic            sh_blz;

  logic [7:0] an_q;
  logic [6:0] seg_q;
  logic       dp_q;
  logic       fd_q;

  logic [7:0][3:0] in_dig;
  logic            slot_end;
  logic            frame_end;
  logic [7:0]      blank;
  logic            zero_above;

  assign in_dig = {bus.tenMil, bus.mil, bus.hundredThousand, bus.tenThousand,
                   bus.thousand, bus.hundred, bus.ten, bus.one};

  assign slot_end  = (div == DIV_LAST);
  assign frame_end = slot_end && (idx == 3'd7);

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  // Walk from the most significant digit down; a digit is blanked while every
  // digit at or above it is zero with no decimal point lit. Digit 0 never blanks.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    blank      = '0;
    zero_above = sh_blz;
    for (int i = 7; i >= 1; i--) begin
      zero_above = zero_above && (sh_dig[i] == 4'd0) && !sh_dp[i];
      blank[i]   = zero_above;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the shadow digit bank is an ordinary register set and is cleared by reset, unlike a RAM.
    if (rst) begin
      div    <= '0;
      idx    <= '0;
      sh_dig <= '0;
      sh_dp  <= '0;
      sh_blz <= 1'b0;
      an_q   <= 8'hFF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      fd_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
      if (slot_end) begin
        div <= '0;
        idx <= idx + 3'd1;
      end else begin
        div <= div + 1'b1;
      end

      if (frame_end) begin
        sh_dig <= in_dig;
        sh_dp  <= bus.dp_sel;
        sh_blz <= bus.blank_lz;
      end

      fd_q <= frame_end;

      if (blank[idx]) begin
        an_q  <= 8'hFF;
        seg_q <= 7'h7F;
        dp_q  <= 1'b1;
      end else begin
        // Segments switch at slot start; the anode waits out the guard window.
        an_q  <= (div >= DIV_GUARD) ? ~(8'h01 << idx) : 8'hFF;
        seg_q <= decode(sh_dig[idx]);
        dp_q  <= ~sh_dp[idx];
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan8.sv
// Scoreboard bench for seg_scan8: stimulus pushes per-cycle expected display
// states, a negedge monitor pops and compares them against the DUT outputs.
module tb_seg_scan8;
  localparam int SD    = 8;
  localparam int GD    = 2;
  localparam int FRAME = 8 * SD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   deadline = 32'h7FFF_FFFF;

  seg_scan8_if bus();

  seg_scan8 #(.SCAN_DIV(SD), .GUARD(GD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         when;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t q[$];

  task automatic push_reset(input int when);
    exp_t e;
    e.when = when;
    e.an   = 8'hFF;
    e.seg  = 7'h7F;
    e.dp   = 1'b1;
    e.fd   = 1'b0;
    q.push_back(e);
  endtask

  // segs[i]/blk[i]/dps[i] describe slot i; fbase is the counter cycle where the frame starts.
  task automatic push_frame(input int fbase, input logic [7:0][6:0] segs,
                            input logic [7:0] blk, input logic [7:0] dps, input int n);
    for (int j = 0; j < n; j++) begin
      exp_t e;
      int   slot;
      int   d;
      slot   = j / SD;
      d      = j % SD;
      e.when = fbase + 1 + j;
      e.fd   = (j == FRAME - 1);
      if (blk[slot]) begin
        e.an  = 8'hFF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
      end else begin
        e.an  = (d >= GD) ? ~(8'h01 << slot) : 8'hFF;
        e.seg = segs[slot];
        e.dp  = ~dps[slot];
      end
      q.push_back(e);
    end
  endtask

  task automatic set_digits(input logic [7:0][3:0] d);
    bus.one             = d[0];
    bus.ten             = d[1];
    bus.hundred         = d[2];
    bus.thousand        = d[3];
    bus.tenThousand     = d[4];
    bus.hundredThousand = d[5];
    bus.mil             = d[6];
    bus.tenMil          = d[7];
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].when < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed cyc=%0d expected entry never compared", e.when);
    end
    if (q.size() > 0 && q[0].when == cyc) begin
      e = q.pop_front();
      checks++;
      if (bus.an !== e.an || bus.seg !== e.seg || bus.dp !== e.dp || bus.frame_done !== e.fd) begin
        errors++;
        $display("FAIL scan cyc=%0d an got %h want %h, seg got %h want %h, dp got %b want %b, frame_done got %b want %b",
                 cyc, bus.an, e.an, bus.seg, e.seg, bus.dp, e.dp, bus.frame_done, e.fd);
      end
    end
    if (cyc > deadline && q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout %0d expected entries left got 0 want 0", q.size());
      q.delete();
    end
  end

  initial begin
    int y;
    int base;
    int base2;

    set_digits(32'h9999_9999);
    bus.dp_sel   = 8'h00;
    bus.blank_lz = 1'b0;
    repeat (2) @(negedge clk);

    // Reset held for three edges; first frame shows the cleared shadow (all zeros).
    y    = cyc;
    base = y + 3;
    push_reset(y + 1);
    push_reset(y + 2);
    push_reset(base);
    push_frame(base,         {8{7'h40}}, 8'h00, 8'h00, FRAME);
    push_frame(base + FRAME, {8{7'h10}}, 8'h00, 8'h00, FRAME);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Scan order and guard: digits 1..8.
    wait_cyc(base + FRAME + 10);
    set_digits(32'h8765_4321);
    push_frame(base + 2 * FRAME,
               {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}, 8'h00, 8'h00, FRAME);

    // Leading-zero blanking with hundredThousand = 3.
    wait_cyc(base + 2 * FRAME + 10);
    set_digits(32'h0030_0000);
    bus.blank_lz = 1'b1;
    push_frame(base + 3 * FRAME, {{2{7'h7F}}, 7'h30, {5{7'h40}}}, 8'hC0, 8'h00, FRAME);

    // All zeros: only digit 0 remains.
    wait_cyc(base + 3 * FRAME + 10);
    set_digits(32'h0000_0000);
    push_frame(base + 4 * FRAME, {{7{7'h7F}}, 7'h40}, 8'hFE, 8'h00, FRAME);

    // Decimal point on digit 2 stops blanking at digit 2.
    wait_cyc(base + 4 * FRAME + 10);
    set_digits(32'h0000_0005);
    bus.dp_sel = 8'h04;
    push_frame(base + 5 * FRAME, {{5{7'h7F}}, 7'h40, 7'h40, 7'h12}, 8'hF8, 8'h04, FRAME);

    // Anti-tearing: one = 1, then changed to 7 in slot 3 of the displayed frame.
    wait_cyc(base + 5 * FRAME + 10);
    set_digits(32'h0000_0001);
    bus.dp_sel   = 8'h00;
    bus.blank_lz = 1'b0;
    push_frame(base + 6 * FRAME, {{7{7'h40}}, 7'h79}, 8'h00, 8'h00, FRAME);

    wait_cyc(base + 6 * FRAME + 3 * SD + 2);
    set_digits(32'h0000_0007);
    push_frame(base + 7 * FRAME, {{7{7'h40}}, 7'h78}, 8'h00, 8'h00, FRAME);

    // Change in the snapshot cycle is captured; one cycle later waits a frame.
    wait_cyc(base + 7 * FRAME + FRAME - 1);
    set_digits(32'h0000_0002);
    push_frame(base + 8 * FRAME, {{7{7'h40}}, 7'h24}, 8'h00, 8'h00, FRAME);

    wait_cyc(base + 8 * FRAME);
    set_digits(32'h0000_0003);
    push_frame(base + 9 * FRAME, {{7{7'h40}}, 7'h30}, 8'h00, 8'h00, 5 * SD);

    // Mid-frame reset in slot 5, then an invalid code on tenMil.
    wait_cyc(base + 9 * FRAME + 5);
    set_digits(32'hC000_0003);
    base2 = base + 9 * FRAME + 5 * SD + 1;
    push_reset(base2);
    push_frame(base2,         {8{7'h40}}, 8'h00, 8'h00, FRAME);
    push_frame(base2 + FRAME, {7'h3F, {6{7'h40}}, 7'h30}, 8'h00, 8'h00, FRAME);

    wait_cyc(base2 - 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    deadline = base2 + 2 * FRAME + 2;
    wait_cyc(deadline + 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
